// File: rtl/hit_scorer_pkg.sv
// Shared defaults and state encodings for the whack-a-mole hit judging path.
package hit_scorer_pkg;

  localparam int DEF_NUM_LIGHTS = 9;
  localparam int DEF_POS_W      = 4;
  localparam int DEF_SCORE_W    = 6;
  localparam int DEF_LIVES_W    = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    JUDGE_NONE = 2'd0,
    JUDGE_HIT  = 2'd1,
    JUDGE_MISS = 2'd2
  } judge_t;

endpackage

// File: rtl/hit_scorer_rise_detect.sv
// Registers a level input once, then flags the first cycle it is seen high.
module hit_scorer_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic cur;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= din;
      prev <= cur;
    end
  end

  assign rise = cur & ~prev;

endmodule

// File: rtl/hit_scorer.sv
// Judges key presses against the lit lamp; keeps score and lives for one game.
// state | meaning
// IDLE  | judging off or no window open
// ARMED | window open, awaiting an answer
// DONE  | window answered, further presses ignored
module hit_scorer
  import hit_scorer_pkg::*;
#(
  parameter int NUM_LIGHTS = DEF_NUM_LIGHTS,
  parameter int POS_W      = DEF_POS_W,
  parameter int SCORE_W    = DEF_SCORE_W,
  parameter int LIVES_W    = DEF_LIVES_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic               use_lives,
  input  logic [LIVES_W-1:0] lives_init,
  input  logic               light_change,
  input  logic [POS_W-1:0]   light_pos,
  input  logic               valid_key,
  input  logic [POS_W-1:0]   key,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives_left,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               out_of_lives
);

  localparam logic [POS_W:0] POS_LIMIT = (POS_W+1)'(NUM_LIGHTS);

  logic             lc_rise;
  logic             key_rise;
  logic [POS_W-1:0] light_pos_q;
  logic [POS_W-1:0] key_q;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [POS_W-1:0] target;
  logic [POS_W-1:0] target_nxt;
  logic             pos_ok;
  logic             key_ok;
  judge_t           judge;

  hit_scorer_rise_detect u_lc_rise (
    .clk   (clk),
    .reset (reset),
    .din   (light_change),
    .rise  (lc_rise)
  );

  hit_scorer_rise_detect u_key_rise (
    .clk   (clk),
    .reset (reset),
    .din   (valid_key),
    .rise  (key_rise)
  );

  // Positions travel with their strobes so they stay aligned with the rise flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      light_pos_q <= '0;
      key_q       <= '0;
    end else begin
      light_pos_q <= light_pos;
      key_q       <= key;
    end
  end

  assign pos_ok = ({1'b0, light_pos_q} < POS_LIMIT);
  assign key_ok = ({1'b0, key_q} < POS_LIMIT) && key_rise;

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    judge      = JUDGE_NONE;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lc_rise && pos_ok) begin
            state_nxt  = ST_ARMED;
            target_nxt = light_pos_q;
          end
        end
        ST_ARMED: begin
          // A key arriving with the new window is judged against the old target.
          if (key_ok) begin
            judge = (key_q == target) ? JUDGE_HIT : JUDGE_MISS;
          end else if (lc_rise) begin
            judge = JUDGE_MISS;
          end
          if (lc_rise) begin
            if (pos_ok) begin
              state_nxt  = ST_ARMED;
              target_nxt = light_pos_q;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else if (key_ok) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (lc_rise) begin
            if (pos_ok) begin
              state_nxt  = ST_ARMED;
              target_nxt = light_pos_q;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      target     <= '0;
      score      <= '0;
      lives_left <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      score      <= '0;
      lives_left <= lives_init;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      target     <= target_nxt;
      hit_pulse  <= (judge == JUDGE_HIT);
      miss_pulse <= (judge == JUDGE_MISS);
      if (judge == JUDGE_HIT && score != '1) begin
        score <= score + 1'b1;
      end
      if (judge == JUDGE_MISS && use_lives && lives_left != '0) begin
        lives_left <= lives_left - 1'b1;
      end
    end
  end

  assign out_of_lives = use_lives && (lives_left == '0);

endmodule

// File: tb/tb_hit_scorer.sv
// Scoreboard bench: stimulus pushes expected pulse results, a monitor pops on each pulse.
module tb_hit_scorer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       use_lives = 1'b0;
  logic [3:0] lives_init = 4'd3;
  logic       light_change = 1'b0;
  logic [3:0] light_pos = 4'd0;
  logic       valid_key = 1'b0;
  logic [3:0] key = 4'd0;
  logic [5:0] score;
  logic [3:0] lives_left;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       out_of_lives;

  typedef struct {
    logic       hit;
    logic [5:0] score;
    logic [3:0] lives;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_score = 0;
  int   exp_lives = 0;

  hit_scorer dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .enable       (enable),
    .use_lives    (use_lives),
    .lives_init   (lives_init),
    .light_change (light_change),
    .light_pos    (light_pos),
    .valid_key    (valid_key),
    .key          (key),
    .score        (score),
    .lives_left   (lives_left),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .out_of_lives (out_of_lives)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && (hit_pulse || miss_pulse)) begin
      exp_t e;
      checks++;
      if (hit_pulse && miss_pulse) begin
        failures++;
        $display("FAIL both_pulses: hit=%0b miss=%0b, required at most one", hit_pulse, miss_pulse);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: hit=%0b miss=%0b score=%0d lives=%0d, required no pulse",
                 hit_pulse, miss_pulse, score, lives_left);
      end else begin
        e = exp_q.pop_front();
        if (hit_pulse != e.hit || score != e.score || lives_left != e.lives) begin
          failures++;
          $display("FAIL pulse_result: got hit=%0b score=%0d lives=%0d, required hit=%0b score=%0d lives=%0d",
                   hit_pulse, score, lives_left, e.hit, e.score, e.lives);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_hit();
    exp_t e;
    if (exp_score < 63) exp_score++;
    e.hit = 1'b1; e.score = 6'(exp_score); e.lives = 4'(exp_lives);
    exp_q.push_back(e);
  endtask

  task automatic expect_miss();
    exp_t e;
    if (use_lives && exp_lives > 0) exp_lives--;
    e.hit = 1'b0; e.score = 6'(exp_score); e.lives = 4'(exp_lives);
    exp_q.push_back(e);
  endtask

  task automatic window(input logic [3:0] p);
    light_pos = p; light_change = 1'b1; tick(2);
    light_change = 1'b0; tick(2);
  endtask

  task automatic press(input logic [3:0] k);
    key = k; valid_key = 1'b1; tick(2);
    valid_key = 1'b0; tick(2);
  endtask

  task automatic both(input logic [3:0] k, input logic [3:0] p);
    key = k; light_pos = p; valid_key = 1'b1; light_change = 1'b1; tick(2);
    valid_key = 1'b0; light_change = 1'b0; tick(2);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(1);
    clear = 1'b0; tick(1);
    exp_score = 0; exp_lives = int'(lives_init);
  endtask

  task automatic check_state(input string name, input int s, input int l, input logic ool);
    checks++;
    if (score != 6'(s) || lives_left != 4'(l) || out_of_lives != ool || hit_pulse || miss_pulse) begin
      failures++;
      $display("FAIL %s: got score=%0d lives=%0d ool=%0b hit=%0b miss=%0b, required score=%0d lives=%0d ool=%0b no pulse",
               name, score, lives_left, out_of_lives, hit_pulse, miss_pulse, s, l, ool);
    end
  endtask

  initial begin
    tick(3);
    reset = 1'b0; tick(1);
    do_clear();
    enable = 1'b1;
    window(4'd4); expect_hit(); press(4'd4);
    // reset mid-game wipes everything
    reset = 1'b1; tick(2);
    exp_score = 0; exp_lives = 0;
    check_state("reset_values", 0, 0, 1'b0);
    reset = 1'b0; tick(1);
    do_clear();
    check_state("clear_lives_init", 0, 3, 1'b0);

    window(4'd4); expect_hit(); press(4'd4);
    press(4'd4);
    check_state("second_press_ignored", 1, 3, 1'b0);

    use_lives = 1'b1;
    window(4'd2); expect_miss(); press(4'd7);
    window(4'd3);
    check_state("answered_window_no_miss", 1, 2, 1'b0);

    expect_miss(); window(4'd6);
    expect_miss(); window(4'd6);
    check_state("out_of_lives", 1, 0, 1'b1);
    expect_miss(); window(4'd1);
    expect_miss(); window(4'd5);
    check_state("lives_floor", 1, 0, 1'b1);

    expect_hit(); both(4'd5, 4'd1);
    expect_hit(); press(4'd1);
    both(4'd1, 4'd7);
    expect_hit(); press(4'd7);
    check_state("simultaneous_cases", 4, 0, 1'b1);

    window(4'd9); press(4'd2);
    window(4'd9); press(4'd9);
    check_state("invalid_pos_key", 4, 0, 1'b1);

    window(4'd4);
    lives_init = 4'd3; do_clear();
    press(4'd4);
    check_state("clear_mid_window", 0, 3, 1'b0);

    use_lives = 1'b0;
    for (int i = 0; i < 63; i++) begin
      window(4'(i % 9)); expect_hit(); press(4'(i % 9));
    end
    check_state("score_63", 63, 3, 1'b0);
    window(4'd8); expect_hit(); press(4'd8);
    check_state("score_saturates", 63, 3, 1'b0);

    enable = 1'b0;
    window(4'd2); press(4'd2);
    enable = 1'b1; tick(1);
    press(4'd2);
    check_state("enable_low_ignored", 63, 3, 1'b0);

    tick(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
